// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential multiplier.
// Holds the alu32 control codes (the same values the main decoder uses), the
// operand width, the FSM state type, and a helper that picks the next step
// from the remaining multiplier bits.
package alu_mul_seq_pkg;

   localparam int MUL_WIDTH = 32;

   localparam logic [3:0] ALUCTL_ADD = 4'b0000;
   localparam logic [3:0] ALUCTL_SUB = 4'b1000;
   localparam logic [3:0] ALUCTL_SLL = 4'b0001;
   localparam logic [3:0] ALUCTL_SLT = 4'b0010;
   localparam logic [3:0] ALUCTL_XOR = 4'b0100;
   localparam logic [3:0] ALUCTL_SRL = 4'b0101;
   localparam logic [3:0] ALUCTL_OR  = 4'b0110;
   localparam logic [3:0] ALUCTL_AND = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_ADD  = 3'd2,
      S_SHL  = 3'd3,
      S_SHR  = 3'd4,
      S_DONE = 3'd5
   } mul_state_t;

   // Stop once no multiplier bits remain; add only when the current LSB is set.
   function automatic mul_state_t next_step(input logic [MUL_WIDTH-1:0] mplier);
      if (mplier == '0)
         return S_DONE;
      else if (mplier[0])
         return S_ADD;
      else
         return S_SHL;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer that borrows the shared alu32.
// Produces the low WIDTH bits of a*b using only ADD, SLL-by-1 and SRL-by-1.
//
// state | meaning
// IDLE  | waiting for start; ALU outputs parked at zero
// REQ   | requesting the ALU; first step chosen once granted
// ADD   | acc <= acc + mcand
// SHL   | mcand <= mcand << 1
// SHR   | mplier <= mplier >> 1; next step chosen from the shifted value
// DONE  | one-cycle done pulse; product valid
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, a, b         launch request and operands (sampled in IDLE only)
//   busy, done, product status, completion pulse, result (held until next DONE)
//   alu_req, alu_gnt    ALU ownership handshake with the core-side mux
//   alu_srca/srcb/control/shamt  operands driven to alu32
//   alu_result          alu32 output, combinational in the same cycle
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_srca,
   output logic [WIDTH-1:0] alu_srcb,
   output logic [3:0]       alu_control,
   output logic [4:0]       alu_shamt,
   input  logic [WIDTH-1:0] alu_result
);

   mul_state_t       state, state_nxt;
   logic [WIDTH-1:0] acc, mcand, mplier, product_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         product_q <= '0;
      end else begin
         state <= state_nxt;
         // Product loads on entry to DONE so it is already valid while done is high.
         if (state_nxt == S_DONE && state != S_DONE)
            product_q <= acc;
         case (state)
            S_IDLE: if (start) begin
               mcand  <= a;
               mplier <= b;
               acc    <= '0;
            end
            S_ADD:  if (alu_gnt) acc    <= alu_result;
            S_SHL:  if (alu_gnt) mcand  <= alu_result;
            S_SHR:  if (alu_gnt) mplier <= alu_result;
            default: ;
         endcase
      end
   end

   // ALU outputs depend only on state and frozen registers, so they hold during a stall.
   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      done        = 1'b0;
      alu_req     = 1'b0;
      alu_srca    = '0;
      alu_srcb    = '0;
      alu_control = ALUCTL_ADD;
      alu_shamt   = 5'd0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_REQ;
         end
         S_REQ: begin
            busy    = 1'b1;
            alu_req = 1'b1;
            if (alu_gnt) state_nxt = next_step(mplier);
         end
         S_ADD: begin
            busy        = 1'b1;
            alu_req     = 1'b1;
            alu_srca    = acc;
            alu_srcb    = mcand;
            alu_control = ALUCTL_ADD;
            if (alu_gnt) state_nxt = S_SHL;
         end
         S_SHL: begin
            busy        = 1'b1;
            alu_req     = 1'b1;
            alu_srca    = mcand;
            alu_control = ALUCTL_SLL;
            alu_shamt   = 5'd1;
            if (alu_gnt) state_nxt = S_SHR;
         end
         S_SHR: begin
            busy        = 1'b1;
            alu_req     = 1'b1;
            alu_srca    = mplier;
            alu_control = ALUCTL_SRL;
            alu_shamt   = 5'd1;
            if (alu_gnt) state_nxt = next_step(alu_result);
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural alu32 plus grant mux, table of operand
// vectors with expected product and latency, scoreboard queue, and hand-written
// sequences for stall, mid-operation reset and ignored starts.
module tb_alu_mul_seq;
   import alu_mul_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, alu_req;
   logic [31:0] product, alu_srca, alu_srcb, alu_result;
   logic [3:0]  alu_control;
   logic [4:0]  alu_shamt;
   logic        alu_gnt = 1'b1;

   // Core-side operands seen by alu32 whenever the grant is withdrawn.
   localparam logic [31:0] CORE_SRCA = 32'hA5A5_5A5A;
   localparam logic [31:0] CORE_SRCB = 32'h0F0F_0F0F;
   localparam logic [3:0]  CORE_CTL  = ALUCTL_OR;
   localparam logic [4:0]  CORE_SHAMT = 5'd3;

   logic [31:0] m_srca, m_srcb;
   logic [3:0]  m_ctl;
   logic [4:0]  m_shamt;

   always #5 clk = ~clk;

   always_comb begin
      m_srca  = alu_gnt ? alu_srca    : CORE_SRCA;
      m_srcb  = alu_gnt ? alu_srcb    : CORE_SRCB;
      m_ctl   = alu_gnt ? alu_control : CORE_CTL;
      m_shamt = alu_gnt ? alu_shamt   : CORE_SHAMT;
      case (m_ctl)
         ALUCTL_ADD: alu_result = m_srca + m_srcb;
         ALUCTL_SUB: alu_result = m_srca - m_srcb;
         ALUCTL_SLL: alu_result = m_srca << m_shamt;
         ALUCTL_SRL: alu_result = m_srca >> m_shamt;
         ALUCTL_SLT: alu_result = {31'd0, $signed(m_srca) < $signed(m_srcb)};
         ALUCTL_XOR: alu_result = m_srca ^ m_srcb;
         ALUCTL_OR:  alu_result = m_srca | m_srcb;
         ALUCTL_AND: alu_result = m_srca & m_srcb;
         default:    alu_result = '0;
      endcase
   end

   alu_mul_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product),
      .alu_req(alu_req), .alu_gnt(alu_gnt),
      .alu_srca(alu_srca), .alu_srcb(alu_srcb),
      .alu_control(alu_control), .alu_shamt(alu_shamt),
      .alu_result(alu_result)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_p;
      int          exp_lat;
      int          stall_at;
      int          stall_len;
      logic [31:0] stall_srca;
      logic [3:0]  stall_ctl;
      bit          poke;
   } vec_t;

   typedef struct {
      logic [31:0] p;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_cmp = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Cycles from the start edge to the DONE cycle, with grant held high.
   function automatic int lat_model(input logic [31:0] bb);
      int top = -1;
      int lat = 2;
      for (int i = 0; i < 32; i++)
         if (bb[i]) top = i;
      for (int i = 0; i <= top; i++)
         lat += bb[i] ? 3 : 2;
      return lat;
   endfunction

   function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                               input logic [31:0] p, input int lat,
                               input int sa, input int sl,
                               input logic [31:0] ss, input logic [3:0] sc,
                               input bit pk);
      vec_t v;
      v.a = va; v.b = vb; v.exp_p = p; v.exp_lat = lat;
      v.stall_at = sa; v.stall_len = sl; v.stall_srca = ss; v.stall_ctl = sc;
      v.poke = pk;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      int   cyc;
      bit   got;
      sb.push_back('{p: v.exp_p, lat: v.exp_lat});
      n_vec++;
      a = v.a;
      b = v.b;
      start = 1'b1;
      @(posedge clk);
      #1;
      cyc = 1;
      got = 1'b0;
      while (!got && cyc <= 400) begin
         start   = v.poke && (cyc == 3);
         alu_gnt = !(v.stall_len > 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
         @(negedge clk);
         if (!alu_gnt) begin
            chk($sformatf("v%0d stall srca c%0d", idx, cyc), alu_srca, v.stall_srca);
            chk($sformatf("v%0d stall ctl c%0d", idx, cyc), {28'd0, alu_control}, {28'd0, v.stall_ctl});
            chk($sformatf("v%0d stall busy c%0d", idx, cyc), {31'd0, busy}, 32'd1);
         end
         if (done) got = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      alu_gnt = 1'b1;
      e = sb.pop_front();
      if (!got) begin
         chk($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
         start = 1'b0;
         return;
      end
      chk($sformatf("v%0d product", idx), product, e.p);
      chk($sformatf("v%0d latency", idx), cyc, e.lat);
      start = v.poke;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (v.poke) begin
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d no second done %0d", idx, k), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d idle busy %0d", idx, k), {31'd0, busy}, 32'd0);
         end
         chk($sformatf("v%0d product held", idx), product, e.p);
      end else begin
         @(negedge clk);
         chk($sformatf("v%0d done pulse width", idx), {31'd0, done}, 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] ra, rb;

      vecs.push_back(mk(32'd3, 32'd5, 32'd15, 10, 0, 0, '0, '0, 1'b0));
      vecs.push_back(mk(32'h1234, 32'd0, 32'd0, 2, 0, 0, '0, '0, 1'b0));
      vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 98, 0, 0, '0, '0, 1'b0));
      vecs.push_back(mk(32'd7, 32'd6, 32'd42, 15, 2, 5, 32'd7, ALUCTL_SLL, 1'b0));
      vecs.push_back(mk(32'd1, 32'h8000_0000, 32'h8000_0000, 67, 0, 0, '0, '0, 1'b0));
      vecs.push_back(mk(32'h10, 32'd1, 32'h10, 5, 0, 0, '0, '0, 1'b0));
      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom;
         vecs.push_back(mk(ra, rb, ra * rb, lat_model(rb), 0, 0, '0, '0, 1'b0));
      end
      vecs.push_back(mk(32'd5, 32'd3, 32'd15, 8, 0, 0, '0, '0, 1'b1));

      #2;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset alu_req", {31'd0, alu_req}, 32'd0);
      chk("reset product", product, 32'd0);
      chk("reset alu_srca", alu_srca, 32'd0);
      chk("reset alu_control", {28'd0, alu_control}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Reset in the middle of the first ADD of 9*9.
      a = 32'd9;
      b = 32'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("mid-add srcb", alu_srcb, 32'd9);
      chk("mid-add busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("reset alu_req drop", {31'd0, alu_req}, 32'd0);
      chk("reset busy drop", {31'd0, busy}, 32'd0);
      chk("reset product clear", product, 32'd0);
      chk("reset alu_srcb clear", alu_srcb, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run_vec(mk(32'd2, 32'd3, 32'd6, 8, 0, 0, '0, '0, 1'b0), 99);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
